// File: rtl/vco_phase_quantizer_if.sv
// rtl/vco_phase_quantizer_if.sv - result handshake bundle between quantizer and decimator
interface vco_phase_quantizer_if #(
  parameter int NUM_CH    = 2,
  parameter int OUT_WIDTH = 9
) ();
  logic [NUM_CH*OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/vco_phase_quantizer.sv
// rtl/vco_phase_quantizer.sv - ring-VCO phase decode, delta and OSR frequency-count accumulation
module vco_phase_quantizer #(
  parameter int PHASE_WIDTH = 11,
  parameter int NUM_CH      = 2,
  parameter int OSR         = 16,
  parameter int OUT_WIDTH   = $clog2(2*PHASE_WIDTH*OSR)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          sample_en,
  input  logic                          mode_raw,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] phase_in,
  vco_phase_quantizer_if.master         out_bus,
  output logic                          overrun,
  input  logic                          clr_overrun
);
  localparam int KW = $clog2(2*PHASE_WIDTH);
  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [KW-1:0] TWO_N    = KW'(2*PHASE_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR-1);

  logic [NUM_CH*PHASE_WIDTH-1:0] sync1, sync2;
  logic [KW-1:0]                 pop    [NUM_CH];
  logic [KW-1:0]                 k_cur  [NUM_CH];
  logic [KW-1:0]                 k_prev [NUM_CH];
  logic [KW-1:0]                 delta  [NUM_CH];
  logic [OUT_WIDTH-1:0]          acc    [NUM_CH];
  logic [NUM_CH*OUT_WIDTH-1:0]   result;
  logic [CW-1:0]                 cnt;
  logic                          primed, mode_q;
  logic                          take, cnt_done, emit, drop;

  // Popcount decode tolerates bubbles; the wrap add keeps delta in 0..2N-1.
  always_comb begin
    result = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = '0;
      for (int i = 0; i < PHASE_WIDTH; i++)
        pop[c] = pop[c] + KW'(sync2[c*PHASE_WIDTH+i]);
      if (sync2[c*PHASE_WIDTH])
        k_cur[c] = pop[c];
      else
        k_cur[c] = (pop[c] == '0) ? '0 : TWO_N - pop[c];
      delta[c] = k_cur[c] - k_prev[c] + ((k_cur[c] < k_prev[c]) ? TWO_N : '0);
      result[c*OUT_WIDTH +: OUT_WIDTH] = mode_q ? OUT_WIDTH'(delta[c])
                                                : acc[c] + OUT_WIDTH'(delta[c]);
    end
  end

  assign take     = enable & sample_en & primed;
  assign cnt_done = (cnt == CNT_LAST);
  assign emit     = take & (mode_q | cnt_done);
  assign drop     = emit & out_bus.out_valid & ~out_bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1             <= '0;
      sync2             <= '0;
      primed            <= 1'b0;
      mode_q            <= 1'b0;
      cnt               <= '0;
      overrun           <= 1'b0;
      out_bus.out_data  <= '0;
      out_bus.out_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        k_prev[c] <= '0;
        acc[c]    <= '0;
      end
    end else begin
      sync1 <= phase_in;
      sync2 <= sync1;

      if (!enable) begin
        primed <= 1'b0;
        cnt    <= '0;
        for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
      end else if (sample_en) begin
        for (int c = 0; c < NUM_CH; c++) k_prev[c] <= k_cur[c];
        if (!primed) begin
          primed <= 1'b1;
          mode_q <= mode_raw;
          cnt    <= '0;
          for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else if (!mode_q) begin
          if (cnt_done) begin
            cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            for (int c = 0; c < NUM_CH; c++) acc[c] <= acc[c] + OUT_WIDTH'(delta[c]);
          end
        end
      end

      // A result arriving while the previous one is still unaccepted is lost.
      if (emit && (!out_bus.out_valid || out_bus.out_ready)) begin
        out_bus.out_data  <= result;
        out_bus.out_valid <= 1'b1;
      end else if (out_bus.out_valid && out_bus.out_ready) begin
        out_bus.out_valid <= 1'b0;
      end

      if (drop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vco_phase_quantizer.sv
// tb/tb_vco_phase_quantizer.sv - directed and randomized checks against a behavioural model
module tb_vco_phase_quantizer;
  localparam int N   = 11;
  localparam int NC  = 2;
  localparam int OSR = 16;
  localparam int OW  = 9;
  localparam int TN  = 2*N;

  logic clk = 1'b0;
  logic rst, enable, sample_en, mode_raw, clr_overrun, overrun;
  logic [NC*N-1:0] phase_in;

  vco_phase_quantizer_if #(.NUM_CH(NC), .OUT_WIDTH(OW)) res_if ();

  vco_phase_quantizer #(.PHASE_WIDTH(N), .NUM_CH(NC), .OSR(OSR), .OUT_WIDTH(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_en   (sample_en),
    .mode_raw    (mode_raw),
    .phase_in    (phase_in),
    .out_bus     (res_if.master),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int  m_kprev [NC];
  int  m_sum   [NC];
  int  m_cnt;
  bit  m_primed, m_mode, m_valid, m_ovr;
  logic [NC*OW-1:0] m_data;
  logic [NC*N-1:0]  hist1, hist2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [N-1:0] p);
    int pc;
    pc = $countones(p);
    if (p[0]) return pc;
    return (TN - pc) % TN;
  endfunction

  function automatic logic [N-1:0] encode(input int k);
    logic [N-1:0] p;
    p = '0;
    if (k >= 1 && k <= N)
      for (int i = 0; i < k; i++) p[i] = 1'b1;
    else if (k > N)
      for (int i = 0; i < TN - k; i++) p[N-1-i] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_kprev[c] = 0;
      m_sum[c]   = 0;
    end
    m_cnt = 0; m_primed = 0; m_mode = 0; m_valid = 0; m_ovr = 0;
    m_data = '0; hist1 = '0; hist2 = '0;
  endtask

  // One clock edge of the reference: sampling uses the phase driven two edges earlier.
  task automatic model_step(input bit en, input bit se, input bit mr, input bit rdy, input bit clr);
    bit emit;
    logic [NC*OW-1:0] r;
    int k, d;
    emit = 0;
    r = '0;
    if (en && se) begin
      if (!m_primed) begin
        for (int c = 0; c < NC; c++) begin
          m_kprev[c] = decode(hist2[c*N +: N]);
          m_sum[c] = 0;
        end
        m_mode = mr; m_cnt = 0; m_primed = 1;
      end else begin
        for (int c = 0; c < NC; c++) begin
          k = decode(hist2[c*N +: N]);
          d = (k - m_kprev[c] + TN) % TN;
          m_kprev[c] = k;
          if (m_mode) r[c*OW +: OW] = OW'(d);
          else m_sum[c] += d;
        end
        if (m_mode) emit = 1;
        else begin
          m_cnt++;
          if (m_cnt == OSR) begin
            for (int c = 0; c < NC; c++) begin
              r[c*OW +: OW] = OW'(m_sum[c]);
              m_sum[c] = 0;
            end
            m_cnt = 0;
            emit = 1;
          end
        end
      end
    end
    if (!en) begin
      m_primed = 0; m_cnt = 0;
      for (int c = 0; c < NC; c++) m_sum[c] = 0;
    end
    if (emit && m_valid && !rdy) m_ovr = 1;
    else if (clr) m_ovr = 0;
    if (emit && (!m_valid || rdy)) begin
      m_data = r; m_valid = 1;
    end else if (m_valid && rdy) m_valid = 0;
    hist2 = hist1;
    hist1 = phase_in;
  endtask

  task automatic cycle(input bit en, input bit se, input bit mr, input bit rdy, input bit clr);
    enable = en; sample_en = se; mode_raw = mr; res_if.out_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    model_step(en, se, mr, rdy, clr);
    #1;
    check("out_valid", res_if.out_valid, m_valid);
    check("out_data", res_if.out_data, m_data);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic set_k(input int k0, input int k1);
    phase_in = {encode(k1), encode(k0)};
  endtask

  task automatic sample(input bit en, input bit mr, input bit rdy_idle, input bit rdy_se, input bit clr);
    cycle(en, 0, mr, rdy_idle, 0);
    cycle(en, 0, mr, rdy_idle, 0);
    cycle(en, 1, mr, rdy_se, clr);
  endtask

  logic [NC*OW-1:0] exp_word;
  logic [N-1:0]     bubble;
  int k0, k1;

  initial begin
    enable = 0; sample_en = 0; mode_raw = 0; clr_overrun = 0;
    res_if.out_ready = 0; phase_in = '0;
    rst = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      phase_in = NC*N'($urandom);
      @(posedge clk);
      #1;
      check("rst_valid", res_if.out_valid, 1'b0);
      check("rst_data", res_if.out_data, '0);
      check("rst_overrun", overrun, 1'b0);
    end
    rst = 0;
    model_reset();

    // Constant rate: ch0 +3 per sample, ch1 still.
    k0 = 0;
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      set_k(k0, 0);
      sample(1, 0, 1, 1, 0);
      if (i == 0) check("prime_no_valid", res_if.out_valid, 1'b0);
      k0 = (k0 + 3) % TN;
    end
    exp_word = {9'd0, 9'd48};
    check("const_valid", res_if.out_valid, 1'b1);
    check("const_data", res_if.out_data, exp_word);

    // Wrap-around in raw mode: 20 -> 1 -> 4.
    cycle(0, 0, 0, 1, 0);
    set_k(20, 0); sample(1, 1, 1, 1, 0);
    set_k(1, 0);  sample(1, 1, 1, 1, 0);
    check("wrap_d1", res_if.out_data[OW-1:0], 9'd3);
    set_k(4, 0);  sample(1, 1, 1, 1, 0);
    check("wrap_d2", res_if.out_data[OW-1:0], 9'd3);
    check("wrap_valid", res_if.out_valid, 1'b1);

    // Backpressure.
    cycle(0, 0, 0, 1, 0);
    set_k(0, 0); sample(1, 1, 0, 0, 0);
    set_k(5, 0); sample(1, 1, 0, 0, 0);
    set_k(7, 0); sample(1, 1, 0, 0, 0);
    check("bp_held", res_if.out_data[OW-1:0], 9'd5);
    check("bp_overrun", overrun, 1'b1);
    cycle(1, 0, 1, 0, 1);
    check("bp_clr", overrun, 1'b0);
    set_k(10, 0); sample(1, 1, 0, 1, 0);
    check("bp_replace", res_if.out_data[OW-1:0], 9'd3);
    check("bp_no_ovr", overrun, 1'b0);

    // Enable drop after 7 samples discards the partial sum.
    cycle(0, 0, 0, 1, 0);
    k0 = 0;
    for (int i = 0; i < 8; i++) begin
      set_k(k0, 0); sample(1, 0, 1, 1, 0); k0 = (k0 + 2) % TN;
    end
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      set_k(k0, 0); sample(1, 0, 1, 1, 0); k0 = (k0 + 1) % TN;
    end
    check("endrop_valid", res_if.out_valid, 1'b1);
    check("endrop_sum", res_if.out_data[OW-1:0], 9'd16);

    // Bubble code decodes by popcount.
    cycle(0, 0, 0, 1, 0);
    set_k(0, 0); sample(1, 1, 1, 1, 0);
    bubble = 11'b00000000101;
    phase_in = {encode(0), bubble};
    sample(1, 1, 1, 1, 0);
    check("bubble_k", res_if.out_data[OW-1:0], 9'd2);

    // Full-scale advance, 21 per sample.
    cycle(0, 0, 0, 1, 0);
    k0 = 0;
    for (int i = 0; i < 17; i++) begin
      set_k(k0, 0); sample(1, 0, 1, 1, 0); k0 = (k0 + 21) % TN;
    end
    check("fullscale", res_if.out_data[OW-1:0], 9'd336);

    // Randomized traffic against the model.
    k0 = 0; k1 = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) cycle(0, 1, 0, 1'($urandom), 0);
      k0 = (k0 + $urandom_range(0, TN-1)) % TN;
      k1 = (k1 + $urandom_range(0, TN-1)) % TN;
      set_k(k0, k1);
      if ($urandom_range(0, 9) == 0) begin
        bubble = N'($urandom);
        phase_in[N-1:0] = bubble;
        k0 = decode(bubble);
      end
      sample(1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
